econet_rx: RTL and testbench

- Receiver for HDLC-style serial frames (Econet line) with an external line clock.
- Samples the line data on line-clock rising edges, hunts for flags and removes stuffed zeros.
- Assembles bytes LSB-first and reports frame completion, abort, idle line and loss of line clock.
- Sits between the line interface and the packet buffer; the whole block runs on the master clock mclk.

---
 rtl/econet_rx.sv | 203 ++++++++++++++++++++
 tb/tb_econet_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/econet_rx.sv
// econet_rx: HDLC-style Econet line receiver; line clock oversampled on mclk.
// Optional CRC-16/CCITT frame check enabled by defining ECONET_RX_CRC_EN.
//
//   state | meaning
//   HUNT  | no frame open, waiting for a flag
//   FLAG  | flag(s) seen, waiting for the first committed data bit
//   DATA  | inside a frame, assembling bytes
module econet_rx #(
  parameter int NO_CLOCK_CYCLES = 256,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       rx_clk,
  input  logic       rx_data,
  output logic [7:0] rx_byte,
  output logic       byte_strobe,
  output logic       frame_complete,
  output logic       abort,
  output logic       idle,
  output logic       valid,
  output logic       no_clock
`ifdef ECONET_RX_CRC_EN
  ,
  output logic       crc_ok
`endif
);

  localparam int NCW = (NO_CLOCK_CYCLES < 2) ? 1 : $clog2(NO_CLOCK_CYCLES + 1);
  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_FLAG = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [SYNC_STAGES-1:0] clk_sh, dat_sh;
  logic           clk_d, bit_stb, rise, nc_hit;
  logic [NCW-1:0] nc_cnt;
  logic [1:0]     st, st_n;
  logic [7:0]     win, win_n, sr, sr_n;
  logic [3:0]     win_cnt, wcnt_n, ones, ones_n;
  logic [2:0]     bit_cnt, bc_n, c1, c1_n;
  logic           got_byte, gb_n, drain, drain_n, idle_n;
  logic           commit, cbit, flag_hit, in_data, stuffed;
  logic           byte_done, fc_n, ab_n;
`ifdef ECONET_RX_CRC_EN
  logic [15:0]    crc, crc_n;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[0] ^ b;
    crc_step = {1'b0, c[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
  endfunction
`endif

  assign rise   = clk_sh[SYNC_STAGES-1] & ~clk_d;
  assign nc_hit = !rise && !no_clock && (nc_cnt == NCW'(NO_CLOCK_CYCLES - 1));
  assign valid  = (st == ST_DATA);

  always_comb begin
    st_n      = st;
    win_n     = win;
    wcnt_n    = win_cnt;
    ones_n    = ones;
    idle_n    = idle;
    drain_n   = drain;
    sr_n      = sr;
    bc_n      = bit_cnt;
    gb_n      = got_byte;
    c1_n      = c1;
`ifdef ECONET_RX_CRC_EN
    crc_n     = crc;
`endif
    byte_done = 1'b0;
    fc_n      = 1'b0;
    ab_n      = 1'b0;
    commit    = 1'b0;
    cbit      = win[0];
    flag_hit  = 1'b0;
    in_data   = 1'b0;
    stuffed   = 1'b0;
    if (bit_stb) begin
      // the oldest bit leaves the window and is committed before the new bit is judged
      commit   = (win_cnt == 4'd8);
      win_n    = {dat_sh[SYNC_STAGES-1], win[7:1]};
      wcnt_n   = (win_cnt == 4'd8) ? 4'd8 : win_cnt + 4'd1;
      flag_hit = (wcnt_n == 4'd8) && (win_n == 8'h7E);
      ones_n   = dat_sh[SYNC_STAGES-1] ? ((ones == 4'd15) ? 4'd15 : ones + 4'd1) : 4'd0;
      idle_n   = (ones_n == 4'd15);
      in_data  = commit && (st == ST_DATA || st == ST_FLAG);
      if (commit && st == ST_FLAG) begin
        st_n    = ST_DATA;
        bc_n    = 3'd0;
        gb_n    = 1'b0;
        c1_n    = 3'd0;
        drain_n = 1'b0;
`ifdef ECONET_RX_CRC_EN
        crc_n   = 16'hFFFF;
`endif
      end
      // after an abort, bits that were already in flight still finish their byte
      if (in_data || (commit && drain)) begin
        stuffed = in_data && !cbit && (c1_n == 3'd5);
        if (in_data)
          c1_n = cbit ? ((c1_n == 3'd7) ? 3'd7 : c1_n + 3'd1) : 3'd0;
        if (!stuffed) begin
          sr_n = {cbit, sr[7:1]};
          bc_n = bc_n + 3'd1;
`ifdef ECONET_RX_CRC_EN
          if (in_data)
            crc_n = crc_step(crc_n, cbit);
`endif
          if (bc_n == 3'd0) begin
            byte_done = 1'b1;
            gb_n      = 1'b1;
            drain_n   = 1'b0;
          end
        end
      end
      if (flag_hit) begin
        wcnt_n  = 4'd0;
        if (st_n == ST_DATA)
          fc_n = gb_n && (bc_n == 3'd0);
        st_n    = ST_FLAG;
        drain_n = 1'b0;
      end else if (ones_n == 4'd7) begin
        if (st_n == ST_DATA) begin
          ab_n    = 1'b1;
          drain_n = (bc_n != 3'd0);
        end
        st_n = ST_HUNT;
      end
    end
    if (no_clock || nc_hit) begin
      st_n    = ST_HUNT;
      fc_n    = 1'b0;
      ab_n    = 1'b0;
      drain_n = 1'b0;
      wcnt_n  = 4'd0;
    end
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      clk_sh         <= '0;
      dat_sh         <= '0;
      clk_d          <= 1'b0;
      bit_stb        <= 1'b0;
      nc_cnt         <= '0;
      no_clock       <= 1'b0;
      st             <= ST_HUNT;
      win            <= 8'h00;
      win_cnt        <= 4'd0;
      ones           <= 4'd0;
      idle           <= 1'b0;
      drain          <= 1'b0;
      sr             <= 8'h00;
      bit_cnt        <= 3'd0;
      got_byte       <= 1'b0;
      c1             <= 3'd0;
      rx_byte        <= 8'h00;
      byte_strobe    <= 1'b0;
      frame_complete <= 1'b0;
      abort          <= 1'b0;
`ifdef ECONET_RX_CRC_EN
      crc            <= 16'hFFFF;
      crc_ok         <= 1'b0;
`endif
    end else begin
      clk_sh  <= {clk_sh[SYNC_STAGES-2:0], rx_clk};
      dat_sh  <= {dat_sh[SYNC_STAGES-2:0], rx_data};
      clk_d   <= clk_sh[SYNC_STAGES-1];
      bit_stb <= rise;
      if (rise) begin
        nc_cnt   <= '0;
        no_clock <= 1'b0;
      end else if (!no_clock) begin
        nc_cnt <= nc_cnt + NCW'(1);
        if (nc_hit)
          no_clock <= 1'b1;
      end
      st             <= st_n;
      win            <= win_n;
      win_cnt        <= wcnt_n;
      ones           <= ones_n;
      idle           <= idle_n;
      drain          <= drain_n;
      sr             <= sr_n;
      bit_cnt        <= bc_n;
      got_byte       <= gb_n;
      c1             <= c1_n;
      byte_strobe    <= byte_done;
      frame_complete <= fc_n;
      abort          <= ab_n;
      if (byte_done)
        rx_byte <= sr_n;
`ifdef ECONET_RX_CRC_EN
      crc <= crc_n;
      if (fc_n)
        crc_ok <= (crc_n == 16'hF0B8);
`endif
    end
  end

endmodule

// File: tb/tb_econet_rx.sv
// Directed bench for econet_rx: reset, loss of clock, idle and a table of frames.
// With ECONET_RX_CRC_EN defined it also checks crc_ok on good and corrupted frames.
module tb_econet_rx;

  localparam int NCC = 256;
  localparam logic [7:0] FL = 8'b01111110;

  logic       mclk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_clk = 1'b0;
  logic       rx_data = 1'b1;
  logic [7:0] rx_byte;
  logic       byte_strobe, frame_complete, abort, idle, valid, no_clock;
`ifdef ECONET_RX_CRC_EN
  logic       crc_ok;
`endif

  econet_rx #(.NO_CLOCK_CYCLES(NCC), .SYNC_STAGES(2)) dut (
    .mclk(mclk),
    .reset(reset),
    .rx_clk(rx_clk),
    .rx_data(rx_data),
    .rx_byte(rx_byte),
    .byte_strobe(byte_strobe),
    .frame_complete(frame_complete),
    .abort(abort),
    .idle(idle),
    .valid(valid),
    .no_clock(no_clock)
`ifdef ECONET_RX_CRC_EN
    ,
    .crc_ok(crc_ok)
`endif
  );

  always #5 mclk = ~mclk;

  int tests = 0;
  int fails = 0;
  int n_stb, n_fc, n_ab;
  logic [7:0] got[$];
  logic valid_prev = 1'b0;
  logic nc_prev = 1'b0;
  logic crc_seen = 1'b0;

  typedef struct {
    int          gap;
    logic [63:0] pat;   // arrival order: pat[n-1] is sent first
    int          n;
    int          mid;   // bit count after which valid is sampled
    logic        vmid;
    int          nstb;
    logic [23:0] bytes; // first byte in [7:0]
    int          nfc;
    int          nab;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge mclk) begin
    if (byte_strobe) begin
      n_stb++;
      got.push_back(rx_byte);
    end
    if (frame_complete) begin
      n_fc++;
`ifdef ECONET_RX_CRC_EN
      crc_seen = crc_ok;
`endif
    end
    if (abort) n_ab++;
    if (frame_complete || abort)
      check("valid_drop_with_pulse", {30'd0, valid, valid_prev}, 32'd1);
    if (no_clock && !nc_prev)
      check("valid_drop_with_no_clock", {31'd0, valid}, 32'd0);
    valid_prev = valid;
    nc_prev    = no_clock;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx_data = b;
    rx_clk  = 1'b0;
    tick(6);
    rx_clk  = 1'b1;
    tick(6);
  endtask

  task automatic send_pat(input logic [63:0] p, input int n);
    for (int i = 0; i < n; i++) send_bit(p[n-1-i]);
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic clear_mon();
    n_stb = 0;
    n_fc  = 0;
    n_ab  = 0;
    got.delete();
  endtask

`ifdef ECONET_RX_CRC_EN
  task automatic send_crc_frame(input logic flip);
    logic [7:0]  fr[4];
    logic [15:0] c;
    int          run;
    fr[0] = 8'h12;
    fr[1] = 8'h34;
    c = 16'hFFFF;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) begin
        logic fb;
        fb = c[0] ^ fr[k][i];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    c = ~c;
    fr[2] = c[7:0];
    fr[3] = c[15:8];
    if (flip) fr[0][3] = ~fr[0][3];
    send_pat(64'(FL), 8);
    run = 0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 8; i++) begin
        send_bit(fr[k][i]);
        run = fr[k][i] ? run + 1 : 0;
        if (run == 5) begin
          send_bit(1'b0);
          run = 0;
        end
      end
    send_pat(64'(FL), 8);
  endtask
`endif

  initial begin
    vecs[0] = '{1, 64'({FL, 8'b01010101, 8'b00000000, 9'b111110111, FL}), 41, 30, 1'b1,
                3, 24'hFF00AA, 1, 0};
    vecs[1] = '{1, 64'({FL, 8'b10101010, 8'b11111111}), 24, 20, 1'b1,
                1, 24'h000055, 0, 1};
    vecs[2] = '{1, 64'({FL, 8'b11000011, 4'b0101, FL}), 28, 20, 1'b1,
                1, 24'h0000C3, 0, 0};
    vecs[3] = '{0, 64'({8'b10000001, FL}), 16, 12, 1'b1,
                1, 24'h000081, 1, 0};
    vecs[4] = '{1, 64'({FL, FL, 9'b011111010, FL}), 33, 12, 1'b0,
                1, 24'h00007E, 1, 0};
    vecs[5] = '{1, 64'({FL, FL}), 16, 12, 1'b0,
                0, 24'h000000, 0, 0};

    clear_mon();
    tick(5);
    check("reset_outputs", {22'd0, rx_byte, byte_strobe, frame_complete, abort, idle, valid, no_clock}, 32'd0);
    reset = 1'b1;
    tick(NCC - 10);
    check("no_clock_early", {31'd0, no_clock}, 32'd0);
    tick(20);
    check("no_clock_set", {31'd0, no_clock}, 32'd1);

    send_bit(1'b1);
    check("no_clock_cleared", {31'd0, no_clock}, 32'd0);
    send_ones(13);
    check("idle_at_14", {31'd0, idle}, 32'd0);
    send_bit(1'b1);
    check("idle_at_15", {31'd0, idle}, 32'd1);
    send_ones(5);
    check("idle_hold", {31'd0, idle}, 32'd1);
    check("valid_idle", {31'd0, valid}, 32'd0);
    send_bit(1'b0);
    check("idle_cleared", {31'd0, idle}, 32'd0);

    for (int k = 0; k < 6; k++) begin
      if (vecs[k].gap != 0) send_ones(16);
      clear_mon();
      for (int i = 0; i < vecs[k].n; i++) begin
        send_bit(vecs[k].pat[vecs[k].n-1-i]);
        if (i + 1 == vecs[k].mid)
          check($sformatf("v%0d_valid_mid", k), {31'd0, valid}, {31'd0, vecs[k].vmid});
      end
      tick(12);
      check($sformatf("v%0d_strobes", k), n_stb, vecs[k].nstb);
      for (int j = 0; j < vecs[k].nstb; j++) begin
        logic [7:0] b;
        b = (j < got.size()) ? got[j] : 8'hxx;
        check($sformatf("v%0d_byte%0d", k, j), {24'd0, b}, {24'd0, vecs[k].bytes[8*j +: 8]});
      end
      check($sformatf("v%0d_frame_complete", k), n_fc, vecs[k].nfc);
      check($sformatf("v%0d_abort", k), n_ab, vecs[k].nab);
      check($sformatf("v%0d_valid_end", k), {31'd0, valid}, 32'd0);
    end

    // lose the line clock in the middle of a frame
    send_ones(16);
    clear_mon();
    send_pat(64'({FL, 8'b01001000, 8'b01001000}), 24);
    tick(2);
    check("nc_frame_valid", {31'd0, valid}, 32'd1);
    check("nc_frame_byte", {24'd0, (got.size() > 0) ? got[0] : 8'hxx}, 32'h12);
    tick(NCC - 20);
    check("nc_not_yet", {30'd0, no_clock, valid}, 32'd1);
    tick(40);
    check("nc_asserted", {30'd0, no_clock, valid}, 32'd2);
    check("nc_no_frame_complete", n_fc, 0);
    check("nc_no_abort", n_ab, 0);
    send_bit(1'b1);
    check("nc_recovered", {31'd0, no_clock}, 32'd0);

`ifdef ECONET_RX_CRC_EN
    send_ones(16);
    clear_mon();
    send_crc_frame(1'b0);
    tick(12);
    check("crc_good_fc", n_fc, 1);
    check("crc_good_ok", {31'd0, crc_seen}, 32'd1);
    send_ones(16);
    clear_mon();
    send_crc_frame(1'b1);
    tick(12);
    check("crc_bad_fc", n_fc, 1);
    check("crc_bad_ok", {31'd0, crc_seen}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
